traffic_lights_timed: RTL and testbench

TRAFFIC_LIGHTS_TIMED -- requirements
Module: traffic_lights_timed

---
 rtl/traffic_pkg.sv | 36 +++
 rtl/phase_timer.sv | 29 ++
 rtl/traffic_lights_timed.sv | 173 +++++++++++++++++
 tb/tb_traffic_lights_timed.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared state encoding, default phase timings and lamp decode for the timed
// traffic-light controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_RED       = 3'd0,
        ST_RED_AMBER = 3'd1,
        ST_GREEN     = 3'd2,
        ST_AMBER     = 3'd3,
        ST_FLASH     = 3'd4
    } state_e;

    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_T_RED       = 1;
    localparam int unsigned DEF_T_RED_AMBER = 1;
    localparam int unsigned DEF_T_GREEN     = 1;
    localparam int unsigned DEF_T_AMBER     = 1;
    localparam int unsigned DEF_T_PED       = 0;
    localparam int unsigned DEF_FLASH_HALF  = 1;

    // Lamp vector is {red, amber, green}.
    function automatic logic [2:0] lamps_of(input state_e st, input logic flash_on);
        logic [2:0] lamps;
        lamps = 3'b100;
        case (st)
            ST_RED:       lamps = 3'b100;
            ST_RED_AMBER: lamps = 3'b110;
            ST_GREEN:     lamps = 3'b001;
            ST_AMBER:     lamps = 3'b010;
            ST_FLASH:     lamps = {1'b0, flash_on, 1'b0};
            default:      lamps = 3'b100;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one phase; done flags the last counted cycle.
module phase_timer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_VAL = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= CNT_W'(RST_VAL);
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A zero count is treated as expired so a bad load can never stall the FSM.
    assign o_done = (r_count <= CNT_W'(1));

endmodule

// File: rtl/traffic_lights_timed.sv
// Timed traffic-light controller: four-phase cycle with pedestrian walk extension
// and a flashing-amber fault mode. All outputs are registered from next state.
module traffic_lights_timed
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned T_RED       = DEF_T_RED,
    parameter int unsigned T_RED_AMBER = DEF_T_RED_AMBER,
    parameter int unsigned T_GREEN     = DEF_T_GREEN,
    parameter int unsigned T_AMBER     = DEF_T_AMBER,
    parameter int unsigned T_PED       = DEF_T_PED,
    parameter int unsigned FLASH_HALF  = DEF_FLASH_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ped_req,
    input  logic fault,
    output logic red,
    output logic amber,
    output logic green,
    output logic walk
);

    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    if ((T_RED < 1) || (T_RED_AMBER < 1) || (T_GREEN < 1) || (T_AMBER < 1) ||
        (FLASH_HALF < 1)) begin : g_bad_min
        $error("traffic_lights_timed: phase lengths must be at least 1");
    end
    if ((longint'(T_RED) + longint'(T_PED)) > MAX_CNT) begin : g_bad_red_ped
        $error("traffic_lights_timed: T_RED+T_PED does not fit in CNT_W bits");
    end
    if ((longint'(T_RED_AMBER) > MAX_CNT) || (longint'(T_GREEN) > MAX_CNT) ||
        (longint'(T_AMBER) > MAX_CNT) || (longint'(FLASH_HALF) > MAX_CNT)) begin : g_bad_len
        $error("traffic_lights_timed: a phase length does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] L_RED       = CNT_W'(T_RED);
    localparam logic [CNT_W-1:0] L_RED_PED   = CNT_W'(T_RED + T_PED);
    localparam logic [CNT_W-1:0] L_RED_AMBER = CNT_W'(T_RED_AMBER);
    localparam logic [CNT_W-1:0] L_GREEN     = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] L_AMBER     = CNT_W'(T_AMBER);
    localparam logic [CNT_W-1:0] L_FLASH     = CNT_W'(FLASH_HALF);

    state_e           r_state;
    logic             r_ped_pending;
    logic             r_flash_on;
    logic             r_walk;
    logic             r_red;
    logic             r_amber;
    logic             r_green;

    state_e           w_state_nxt;
    logic             w_pend_nxt;
    logic             w_flash_nxt;
    logic             w_walk_nxt;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_done;
    logic [2:0]       w_lamps_nxt;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (T_RED)
    ) u_phase_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_done     (w_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_ped_pending | ped_req;
        w_flash_nxt = r_flash_on;
        w_walk_nxt  = r_walk;
        w_load      = 1'b0;
        w_load_val  = L_RED;
        w_dec       = 1'b0;

        // Fault handling ignores enable so a failed controller always flashes.
        if (fault) begin
            if (r_state != ST_FLASH) begin
                w_state_nxt = ST_FLASH;
                w_load      = 1'b1;
                w_load_val  = L_FLASH;
                w_flash_nxt = 1'b1;
                w_walk_nxt  = 1'b0;
            end else if (w_done) begin
                w_load      = 1'b1;
                w_load_val  = L_FLASH;
                w_flash_nxt = ~r_flash_on;
            end else begin
                w_dec = 1'b1;
            end
        end else if (r_state == ST_FLASH) begin
            w_state_nxt = ST_RED;
            w_load      = 1'b1;
            w_load_val  = L_RED;
            w_walk_nxt  = 1'b0;
        end else if (enable) begin
            if (w_done) begin
                w_load = 1'b1;
                case (r_state)
                    ST_RED: begin
                        w_state_nxt = ST_RED_AMBER;
                        w_load_val  = L_RED_AMBER;
                        w_walk_nxt  = 1'b0;
                    end
                    ST_RED_AMBER: begin
                        w_state_nxt = ST_GREEN;
                        w_load_val  = L_GREEN;
                    end
                    ST_GREEN: begin
                        w_state_nxt = ST_AMBER;
                        w_load_val  = L_AMBER;
                    end
                    ST_AMBER: begin
                        // A request on this very edge is served by the coming red.
                        w_state_nxt = ST_RED;
                        w_pend_nxt  = 1'b0;
                        if (r_ped_pending || ped_req) begin
                            w_load_val = L_RED_PED;
                            w_walk_nxt = 1'b1;
                        end else begin
                            w_load_val = L_RED;
                            w_walk_nxt = 1'b0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_RED;
                        w_load_val  = L_RED;
                        w_walk_nxt  = 1'b0;
                    end
                endcase
            end else begin
                w_dec = 1'b1;
            end
        end
    end

    assign w_lamps_nxt = lamps_of(w_state_nxt, w_flash_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RED;
            r_ped_pending <= 1'b0;
            r_flash_on    <= 1'b0;
            r_walk        <= 1'b0;
            r_red         <= 1'b1;
            r_amber       <= 1'b0;
            r_green       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ped_pending <= w_pend_nxt;
            r_flash_on    <= w_flash_nxt;
            r_walk        <= w_walk_nxt;
            r_red         <= w_lamps_nxt[2];
            r_amber       <= w_lamps_nxt[1];
            r_green       <= w_lamps_nxt[0];
        end
    end

    assign red   = r_red;
    assign amber = r_amber;
    assign green = r_green;
    assign walk  = r_walk;

endmodule

// File: tb/tb_traffic_lights_timed.sv
// Directed bench for traffic_lights_timed: phase lengths, walk extension, enable hold,
// fault flashing, reset priority, plus a default-parameter instance.
module tb_traffic_lights_timed;

    localparam int LR  = 4;  // {red,amber,green} = 100
    localparam int LRA = 6;  // 110
    localparam int LG  = 1;  // 001
    localparam int LA  = 2;  // 010

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic ped_req;
    logic fault;
    logic red, amber, green, walk;

    logic d_en   = 1'b1;
    logic d_zero = 1'b0;
    logic d_red, d_amber, d_green, d_walk;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    traffic_lights_timed #(
        .CNT_W       (8),
        .T_RED       (4),
        .T_RED_AMBER (2),
        .T_GREEN     (5),
        .T_AMBER     (3),
        .T_PED       (3),
        .FLASH_HALF  (2)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .ped_req (ped_req),
        .fault   (fault),
        .red     (red),
        .amber   (amber),
        .green   (green),
        .walk    (walk)
    );

    traffic_lights_timed u_dut_def (
        .clk     (clk),
        .rst     (rst),
        .enable  (d_en),
        .ped_req (d_zero),
        .fault   (d_zero),
        .red     (d_red),
        .amber   (d_amber),
        .green   (d_green),
        .walk    (d_walk)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lamps_now();
        return int'({red, amber, green});
    endfunction

    // Starts on the first sample of a phase, ends on the first sample of the next one.
    task automatic expect_phase(input string tag, input int code, input int len,
                                input logic exp_walk, input int pulse_at, input int hold_at);
        int n;
        int walk_bad;
        int hold_bad;
        n        = 1;
        walk_bad = 0;
        hold_bad = 0;
        check_val({tag, " entry"}, lamps_now(), code);
        forever begin
            if (walk !== exp_walk) walk_bad++;
            if (n == hold_at) begin
                enable = 1'b0;
                repeat (10) begin
                    step();
                    if (lamps_now() != code) hold_bad++;
                end
                enable = 1'b1;
                check_val({tag, " hold"}, hold_bad, 0);
            end
            ped_req = (n == pulse_at);
            step();
            ped_req = 1'b0;
            if ((lamps_now() != code) || (n >= 60)) break;
            n++;
        end
        check_val({tag, " len"}, n, len);
        check_val({tag, " walk"}, walk_bad, 0);
    endtask

    initial begin
        int def_exp[5];
        int flash_exp[6];
        def_exp   = '{LR, LRA, LG, LA, LR};
        flash_exp = '{LA, LA, 0, 0, LA, LA};

        rst     = 1'b1;
        enable  = 1'b0;
        ped_req = 1'b0;
        fault   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_val("reset lamps", lamps_now(), LR);
        check_val("reset walk", int'(walk), 0);
        check_val("default s0", int'({d_red, d_amber, d_green}), def_exp[0]);
        for (int i = 1; i < 5; i++) begin
            step();
            check_val($sformatf("default s%0d", i), int'({d_red, d_amber, d_green}), def_exp[i]);
        end
        check_val("disabled hold", lamps_now(), LR);
        enable = 1'b1;

        // Plain cycle
        expect_phase("red1", LR, 4, 1'b0, -1, -1);
        expect_phase("ra1", LRA, 2, 1'b0, -1, -1);
        expect_phase("green1", LG, 5, 1'b0, -1, -1);
        expect_phase("amber1", LA, 3, 1'b0, -1, -1);
        expect_phase("red2", LR, 4, 1'b0, -1, -1);

        // Pedestrian pulse during green
        expect_phase("ra2", LRA, 2, 1'b0, -1, -1);
        expect_phase("green2 ped", LG, 5, 1'b0, 1, -1);
        expect_phase("amber2", LA, 3, 1'b0, -1, -1);
        expect_phase("red walk", LR, 7, 1'b1, -1, -1);
        expect_phase("ra3", LRA, 2, 1'b0, -1, -1);
        expect_phase("green3", LG, 5, 1'b0, -1, -1);
        expect_phase("amber3", LA, 3, 1'b0, -1, -1);
        expect_phase("red after walk", LR, 4, 1'b0, -1, -1);

        // Enable hold mid-green
        expect_phase("ra4", LRA, 2, 1'b0, -1, -1);
        expect_phase("green hold", LG, 5, 1'b0, -1, 3);

        // Fault during amber
        check_val("amber before fault", lamps_now(), LA);
        fault = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("flash s%0d", i), lamps_now(), flash_exp[i]);
            check_val($sformatf("flash walk s%0d", i), int'(walk), 0);
            if (i == 5) fault = 1'b0;
            step();
        end
        expect_phase("red after flash", LR, 4, 1'b0, -1, -1);
        expect_phase("ra5", LRA, 2, 1'b0, -1, -1);

        // Reset mid-green with a pending request
        check_val("green before rst", lamps_now(), LG);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst mid lamps", lamps_now(), LR);
        check_val("rst mid walk", int'(walk), 0);
        expect_phase("red after rst", LR, 4, 1'b0, -1, -1);
        expect_phase("ra6", LRA, 2, 1'b0, -1, -1);
        expect_phase("green6", LG, 5, 1'b0, -1, -1);
        expect_phase("amber6", LA, 3, 1'b0, -1, -1);
        expect_phase("red pend cleared", LR, 4, 1'b0, -1, -1);

        // Request on the amber->red edge, then another during the walk red
        expect_phase("ra7", LRA, 2, 1'b0, -1, -1);
        expect_phase("green7", LG, 5, 1'b0, -1, -1);
        expect_phase("amber7 edge ped", LA, 3, 1'b0, 3, -1);
        expect_phase("red edge walk", LR, 7, 1'b1, 2, -1);
        expect_phase("ra8", LRA, 2, 1'b0, -1, -1);
        expect_phase("green8", LG, 5, 1'b0, -1, -1);
        expect_phase("amber8", LA, 3, 1'b0, -1, -1);
        expect_phase("red relatched walk", LR, 7, 1'b1, -1, -1);
        expect_phase("ra9", LRA, 2, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
